exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 155 +++++++++++++++
 tb/tb_exe_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// EX stage: operand muxing, ALU, branch target and EX/MEM register.
// Optional multi-cycle unsigned divider (DIVU/REMU) built when EXE_DIV_EN is defined.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_flush,
  input  logic        RegDst,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        Alusrc1,
  input  logic        Alusrc2,
  input  logic        RegWrite,
  input  logic [1:0]  MemWrite,
  input  logic [1:0]  MemRead,
  input  logic [4:0]  Aluctr,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [31:0] immi1,
  input  logic [31:0] immi2,
  input  logic [31:0] pc_4,
  output logic        ex_stall,
  output logic        mem_RegWrite,
  output logic        mem_MemtoReg,
  output logic        mem_Branch,
  output logic        mem_zero,
  output logic [1:0]  mem_MemWrite,
  output logic [1:0]  mem_MemRead,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_busB,
  output logic [31:0] mem_target,
  output logic [4:0]  mem_wreg
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA = 5'd10, OP_LUI  = 5'd11;
  localparam logic [4:0] OP_DIVU = 5'd12, OP_REMU = 5'd13;

  logic [31:0] a, b, alu_res, alu_sel;
  logic        is_div;

  assign a      = Alusrc1 ? immi1 : busA;
  assign b      = Alusrc2 ? immi2 : busB;
  assign is_div = (Aluctr == OP_DIVU) || (Aluctr == OP_REMU);

  always_comb begin
    alu_res = 32'd0;
    case (Aluctr)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {31'd0, a < b};
      OP_SLL:  alu_res = b << a[4:0];
      OP_SRL:  alu_res = b >> a[4:0];
      OP_SRA:  alu_res = $unsigned($signed(b) >>> a[4:0]);
      OP_LUI:  alu_res = {b[15:0], 16'd0};
`ifdef EXE_DIV_EN
      // Divide by zero resolves in one cycle; non-zero divisors go through the FSM.
      OP_DIVU: alu_res = (b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
      OP_REMU: alu_res = (b == 32'd0) ? a : 32'd0;
`endif
      default: alu_res = 32'd0;
    endcase
  end

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        is_rem;
  logic        start;
  logic [32:0] r_sh, diff;

  assign start    = (state == IDLE) && is_div && (b != 32'd0);
  assign ex_stall = !reset && !ex_flush && (start || (state == BUSY));
  assign alu_sel  = (state == DONE) ? (is_rem ? rem : quo) : alu_res;

  // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  assign r_sh = {rem, quo[31]};
  assign diff = r_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset || ex_flush) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      dvs    <= 32'd0;
      is_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= BUSY;
          cnt    <= 6'd32;
          quo    <= a;
          rem    <= 32'd0;
          dvs    <= b;
          is_rem <= (Aluctr == OP_REMU);
        end
        BUSY: begin
          if (diff[32]) begin
            rem <= r_sh[31:0];
            quo <= {quo[30:0], 1'b0};
          end else begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign ex_stall = 1'b0;
  assign alu_sel  = alu_res;
`endif

  always_ff @(posedge clk) begin
    if (reset || ex_flush || ex_stall) begin
      mem_RegWrite <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_Branch   <= 1'b0;
      mem_zero     <= 1'b0;
      mem_MemWrite <= 2'd0;
      mem_MemRead  <= 2'd0;
      mem_alu      <= 32'd0;
      mem_busB     <= 32'd0;
      mem_target   <= 32'd0;
      mem_wreg     <= 5'd0;
    end else begin
      mem_RegWrite <= RegWrite;
      mem_MemtoReg <= MemtoReg;
      mem_Branch   <= Branch;
      mem_zero     <= (a - b) == 32'd0;
      mem_MemWrite <= MemWrite;
      mem_MemRead  <= MemRead;
      mem_alu      <= alu_sel;
      mem_busB     <= busB;
      mem_target   <= pc_4 + {immi2[29:0], 2'b00};
      mem_wreg     <= RegDst ? rd : rt;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: scoreboard of expected EX/MEM contents, checked after each edge.
module tb_exe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] busb;
    logic [31:0] target;
    logic [4:0]  wreg;
    logic        zero;
    logic        rw;
    logic        m2r;
    logic        br;
    logic [1:0]  mw;
    logic [1:0]  mr;
  } out_t;

  logic        clk, reset, ex_flush;
  logic        RegDst, Branch, MemtoReg, Alusrc1, Alusrc2, RegWrite;
  logic [1:0]  MemWrite, MemRead;
  logic [4:0]  Aluctr, rt, rd;
  logic [31:0] busA, busB, immi1, immi2, pc_4;
  logic        ex_stall, mem_RegWrite, mem_MemtoReg, mem_Branch, mem_zero;
  logic [1:0]  mem_MemWrite, mem_MemRead;
  logic [31:0] mem_alu, mem_busB, mem_target;
  logic [4:0]  mem_wreg;

  exe_stage dut (
    .clk(clk), .reset(reset), .ex_flush(ex_flush),
    .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg),
    .Alusrc1(Alusrc1), .Alusrc2(Alusrc2), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .Aluctr(Aluctr), .rt(rt), .rd(rd),
    .busA(busA), .busB(busB), .immi1(immi1), .immi2(immi2), .pc_4(pc_4),
    .ex_stall(ex_stall), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_Branch(mem_Branch), .mem_zero(mem_zero), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .mem_alu(mem_alu), .mem_busB(mem_busB),
    .mem_target(mem_target), .mem_wreg(mem_wreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t obs;
  assign obs = {mem_alu, mem_busB, mem_target, mem_wreg, mem_zero, mem_RegWrite,
                mem_MemtoReg, mem_Branch, mem_MemWrite, mem_MemRead};

  int   total = 0;
  int   bad   = 0;
  out_t sb[$];

  // Reference outputs for the inputs currently driven.
  function automatic out_t model();
    out_t e;
    logic [31:0] va, vb;
    va = Alusrc1 ? immi1 : busA;
    vb = Alusrc2 ? immi2 : busB;
    case (Aluctr)
      5'd0:  e.alu = va + vb;
      5'd1:  e.alu = va - vb;
      5'd2:  e.alu = va & vb;
      5'd3:  e.alu = va | vb;
      5'd4:  e.alu = va ^ vb;
      5'd5:  e.alu = ~(va | vb);
      5'd6:  e.alu = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      5'd7:  e.alu = (va < vb) ? 32'd1 : 32'd0;
      5'd8:  e.alu = vb << va[4:0];
      5'd9:  e.alu = vb >> va[4:0];
      5'd10: e.alu = $unsigned($signed(vb) >>> va[4:0]);
      5'd11: e.alu = {vb[15:0], 16'h0000};
`ifdef EXE_DIV_EN
      5'd12: e.alu = (vb == 0) ? 32'hFFFF_FFFF : va / vb;
      5'd13: e.alu = (vb == 0) ? va : va % vb;
`endif
      default: e.alu = 32'd0;
    endcase
    e.busb   = busB;
    e.target = pc_4 + immi2 * 4;
    e.wreg   = RegDst ? rd : rt;
    e.zero   = (va == vb);
    e.rw     = RegWrite;
    e.m2r    = MemtoReg;
    e.br     = Branch;
    e.mw     = MemWrite;
    e.mr     = MemRead;
    return e;
  endfunction

  task automatic tick(input out_t e, input string tag);
    out_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    total++;
    assert (obs === x) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, x);
    end
  endtask

  task automatic chk_stall(input logic e, input string tag);
    total++;
    assert (ex_stall === e) else begin
      bad++;
      $error("FAIL %s ex_stall obs=%b exp=%b", tag, ex_stall, e);
    end
  endtask

  task automatic chk_val(input logic [31:0] o, input logic [31:0] e, input string tag);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic set_op(input logic [4:0] ctr, input logic [31:0] a, input logic [31:0] b);
    Aluctr   = ctr;
    busA     = a;
    busB     = b;
    Alusrc1  = 1'b0;
    Alusrc2  = 1'b0;
    RegWrite = 1'b1;
    Branch   = 1'b0;
    RegDst   = 1'($urandom_range(0, 1));
    MemtoReg = 1'($urandom_range(0, 1));
    MemWrite = 2'($urandom_range(0, 3));
    MemRead  = 2'($urandom_range(0, 3));
    rt       = 5'($urandom);
    rd       = 5'($urandom);
    immi1    = $urandom;
    immi2    = $urandom;
    pc_4     = $urandom;
  endtask

  task automatic alu(input logic [4:0] ctr, input logic [31:0] a, input logic [31:0] b,
                     input string tag);
    set_op(ctr, a, b);
    chk_stall(1'b0, tag);
    tick(model(), tag);
  endtask

`ifdef EXE_DIV_EN
  task automatic div_run(input logic [4:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    int n;
    n = 0;
    set_op(ctr, a, b);
    while (ex_stall === 1'b1 && n < 40) begin
      n++;
      tick('0, "div_bubble");
      if (n == 5) begin busA = 32'hDEAD_BEEF; busB = 32'h0; end
      if (n == 30) begin busA = a; busB = b; end
    end
    chk_val(32'(n), 32'd33, "div_stall_len");
    chk_stall(1'b0, "div_done_stall");
    tick(model(), tag);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ex_flush = 1'b0;
    reset    = 1'b1;
    set_op(5'd12, 32'd100, 32'd7);
    #1;
    chk_stall(1'b0, "stall_in_reset");
    tick('0, "reset_state");
    set_op(5'd0, 32'd0, 32'd0);
    tick('0, "reset_hold");
    reset = 1'b0;
    chk_stall(1'b0, "stall_after_reset");

    alu(5'd0, 32'h7FFF_FFFF, 32'd1, "add_wrap");
    chk_val(mem_alu, 32'h8000_0000, "add_const");
    chk_val({31'd0, mem_zero}, 32'd0, "add_zero");
    alu(5'd1, 32'd0, 32'd1, "sub_wrap");
    alu(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    alu(5'd3, 32'hF000_0001, 32'h0000_1000, "or");
    alu(5'd4, 32'hAAAA_5555, 32'hFFFF_0000, "xor");
    alu(5'd5, 32'h1234_0000, 32'h0000_5678, "nor");
    alu(5'd6, 32'hFFFF_FFFF, 32'd1, "slt");
    chk_val(mem_alu, 32'd1, "slt_const");
    alu(5'd7, 32'hFFFF_FFFF, 32'd1, "sltu");
    chk_val(mem_alu, 32'd0, "sltu_const");
    alu(5'd8, 32'd35, 32'h0000_0003, "sll");
    alu(5'd9, 32'd4, 32'h8000_00F0, "srl");
    alu(5'd10, 32'd31, 32'h8000_0000, "sra");
    alu(5'd11, 32'd0, 32'hABCD_1234, "lui");
    alu(5'd14, 32'd5, 32'd6, "code14");
    alu(5'd31, 32'd5, 32'd6, "code31");

    set_op(5'd0, 32'd1, 32'd2);
    Alusrc1 = 1'b1; Alusrc2 = 1'b1;
    immi1 = 32'd1000; immi2 = 32'd24;
    tick(model(), "alusrc_imm");
    chk_val(mem_alu, 32'd1024, "alusrc_const");

    set_op(5'd1, 32'd5, 32'd5);
    Branch = 1'b1; pc_4 = 32'h100; immi2 = 32'hFFFF_FFFE;
    tick(model(), "branch");
    chk_val(mem_target, 32'h0000_00F8, "branch_target");
    chk_val({31'd0, mem_zero}, 32'd1, "branch_zero");

    set_op(5'd0, 32'd3, 32'd4);
    ex_flush = 1'b1;
    tick('0, "flush_alu");
    ex_flush = 1'b0;

    alu(5'd12, 32'd5, 32'd0, "divu_by0");
    alu(5'd13, 32'd5, 32'd0, "remu_by0");

`ifdef EXE_DIV_EN
    chk_val(32'(0), 32'(0) + 32'(sb.size()), "sb_empty");
    div_run(5'd12, 32'd100, 32'd7, "divu_100_7");
    chk_val(mem_alu, 32'd14, "divu_const");
    chk_val({31'd0, mem_RegWrite}, 32'd1, "divu_regwrite");
    div_run(5'd13, 32'd100, 32'd7, "remu_100_7");
    chk_val(mem_alu, 32'd2, "remu_const");
    div_run(5'd12, 32'hFFFF_FFFF, 32'h0001_0003, "divu_big");
    div_run(5'd13, 32'hDEAD_BEEF, 32'h0000_1235, "remu_big");

    set_op(5'd12, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick('0, "flush_pre");
    ex_flush = 1'b1;
    chk_stall(1'b0, "flush_stall");
    tick('0, "flush_busy");
    ex_flush = 1'b0;
    alu(5'd0, 32'd9, 32'd9, "after_flush");

    set_op(5'd13, 32'd100, 32'd7);
    for (int i = 0; i < 20; i++) tick('0, "reset_pre");
    reset = 1'b1;
    ex_flush = 1'b1;
    chk_stall(1'b0, "reset_busy_stall");
    tick('0, "reset_busy");
    reset = 1'b0;
    ex_flush = 1'b0;
    alu(5'd0, 32'd11, 32'd22, "after_reset");
`else
    alu(5'd12, 32'd100, 32'd7, "divu_off");
    alu(5'd13, 32'd100, 32'd7, "remu_off");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
